// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit serial CPU datapath: widths, the
// writeback FSM state encoding and the register address type.
package cpu_pkg;

  localparam int WIDTH  = 16;
  localparam int REG_AW = 3;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/reg_wb_deser.sv
// Bit-serial writeback deserializer: gathers an LSB-first result and issues
// one registered write cycle on the register-file write bus.
module reg_wb_deser
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int AW    = cpu_pkg::REG_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    dest,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rd_we,
  output logic [AW-1:0]    rd,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = $clog2(WIDTH + 1);

  wb_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [AW-1:0]    dest_q, dest_d;
  logic             done_d, rd_we_d;
  logic [AW-1:0]    rd_d;
  logic [WIDTH-1:0] rd_data_d;

  // NOTE: every variable gets a default at the top of always_comb, so no
  // path through the case tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    dest_d    = dest_q;
    done_d    = 1'b0;
    rd_we_d   = 1'b0;
    rd_d      = '0;
    rd_data_d = '0;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, WRITE: begin
          // A start in WRITE chains the next result with no idle bubble.
          if (start) begin
            dest_d  = dest;
            cnt_d   = '0;
            shreg_d = '0;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            shreg_d = {bit_in, shreg_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
              // Bus values are computed here so they are registered on entry
              // to WRITE; r0 writes keep the bus quiet but still signal done.
              state_d = WRITE;
              done_d  = 1'b1;
              if (dest_q != '0) begin
                rd_we_d   = 1'b1;
                rd_d      = dest_q;
                rd_data_d = shreg_d;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dest_q  <= '0;
      done    <= 1'b0;
      rd_we   <= 1'b0;
      rd      <= '0;
      rd_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      dest_q  <= dest_d;
      done    <= done_d;
      rd_we   <= rd_we_d;
      rd      <= rd_d;
      rd_data <= rd_data_d;
    end
  end

  assign busy = (state_q == SHIFT) || (state_q == WRITE);

endmodule

// File: tb/tb_reg_wb_deser.sv
// Randomized bench for reg_wb_deser: a transaction scoreboard predicts the
// cycle and contents of every write; the bus is checked on every cycle.
module tb_reg_wb_deser;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] dest;
  logic          bit_valid;
  logic          bit_in;
  logic          abort;
  logic          busy;
  logic          done;
  logic          rd_we;
  logic [AW-1:0] rd;
  logic [W-1:0]  rd_data;

  reg_wb_deser #(.WIDTH(W), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dest      (dest),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rd_we     (rd_we),
    .rd        (rd),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Scoreboard: cycle index -> expected write
  int           sched_dest[int];
  logic [W-1:0] sched_data[int];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Bus monitor: done/rd_we/rd/rd_data are all zero except in a scheduled write cycle.
  logic [63:0] exp_bus;
  always @(negedge clk) begin
    if (mon_en) begin
      if (sched_dest.exists(cyc)) begin
        if (sched_dest[cyc] != 0)
          exp_bus = {40'd0, 1'b1, 1'b1, AW'(sched_dest[cyc]), sched_data[cyc]};
        else
          exp_bus = {40'd0, 1'b1, 1'b0, {AW{1'b0}}, {W{1'b0}}};
      end else begin
        exp_bus = '0;
      end
      check("bus{done,we,rd,data}", {40'd0, done, rd_we, rd, rd_data}, exp_bus);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_quiet();
    start     = 1'b0;
    abort     = 1'b0;
    rst       = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  // Idle cycles with garbage on the serial inputs; none of it may be consumed.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive_quiet();
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      abort     = 1'($urandom);
      step();
      check("busy_idle", 64'(busy), 64'd0);
    end
  endtask

  // One capture starting in the current cycle. mode 0: complete, 1: abort after
  // kill_at bits, 2: rst after kill_at bits. A complete capture returns in its
  // WRITE cycle so the caller may chain the next start back-to-back.
  task automatic capture(input int d, input logic [W-1:0] value, input int stalls,
                         input int mode, input int kill_at);
    int bits_left;
    int stalls_left;
    int sent;
    bits_left   = (mode == 0) ? W : kill_at;
    stalls_left = stalls;
    sent        = 0;
    if (mode == 0) begin
      sched_dest[cyc + 1 + W + stalls] = d;
      sched_data[cyc + 1 + W + stalls] = value;
    end
    drive_quiet();
    start = 1'b1;
    dest  = AW'(d);
    step();
    check("busy_after_start", 64'(busy), 64'd1);
    while (bits_left > 0) begin
      drive_quiet();
      start = 1'($urandom);   // must be ignored while shifting
      dest  = AW'($urandom);
      if (stalls_left > 0 &&
          $urandom_range(0, stalls_left + bits_left - 2) < stalls_left) begin
        bit_in = 1'($urandom);
        stalls_left--;
      end else begin
        bit_valid = 1'b1;
        bit_in    = value[sent];
        sent++;
        bits_left--;
      end
      step();
    end
    if (mode == 0) begin
      check("busy_in_write", 64'(busy), 64'd1);
    end else begin
      drive_quiet();
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      if (mode == 1) abort = 1'b1;
      else           rst   = 1'b1;
      step();
      drive_quiet();
      check("busy_after_kill", 64'(busy), 64'd0);
      check("outs_after_kill", {61'd0, done, rd_we, busy}, 64'd0);
    end
  endtask

  initial begin
    int mode;
    drive_quiet();
    dest = '0;
    rst  = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("reset_outs", {40'd0, busy, done, rd_we, rd, rd_data}, 64'd0);
    mon_en = 1'b1;
    idle(2);

    // Continuous bits to r3
    capture(3, 16'hA5C3, 0, 0, 0);
    idle(2);
    // Same result with 5 stall cycles
    capture(3, 16'hA5C3, 5, 0, 0);
    idle(2);
    // Write to r0: done only, bus stays quiet
    capture(0, 16'hFFFF, 0, 0, 0);
    idle(2);
    // Abort after 8 bits, then a clean capture
    capture(4, 16'hBEEF, 2, 1, 8);
    idle(1);
    capture(5, 16'h1234, 0, 0, 0);
    idle(1);
    // start together with abort in IDLE is dropped
    drive_quiet();
    start = 1'b1;
    abort = 1'b1;
    dest  = 3'd7;
    step();
    check("abort_start_idle", 64'(busy), 64'd0);
    idle(1);
    // Back-to-back results
    capture(2, 16'h0001, 0, 0, 0);
    capture(6, 16'h8000, 0, 0, 0);
    idle(2);
    // Reset at bit 10, then a fresh run
    capture(1, 16'h5A5A, 3, 2, 10);
    check("reset_mid_outs", {40'd0, busy, done, rd_we, rd, rd_data}, 64'd0);
    capture(7, 16'hC0DE, 0, 0, 0);
    idle(1);

    // Random traffic
    for (int t = 0; t < 40; t++) begin
      mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      capture(int'($urandom_range(0, 7)), W'($urandom), int'($urandom_range(0, 6)),
              mode, int'($urandom_range(0, W - 1)));
      if (mode == 0 && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
